// File: rtl/gate_model_bist.sv
// gate_model_bist: BIST harness for a 23-in / 10-out combinational gate model.
// An LFSR drives the model inputs and a MISR compacts its outputs; after
// PATTERNS patterns the signature is compared against a golden value.
// Optional build macro GATE_MODEL_BIST_TOGGLE_EN adds the toggle_mask output
// and makes pass also require every model output to have toggled during the run.
module gate_model_bist #(
  parameter int unsigned       N_IN      = 23,
  parameter int unsigned       N_OUT     = 10,
  parameter int unsigned       PATTERNS  = 256,
  parameter logic [N_IN-1:0]   LFSR_TAPS = 23'h420000,
  parameter logic [N_IN-1:0]   LFSR_SEED = 23'h000001,
  parameter logic [N_OUT-1:0]  MISR_TAPS = 10'h240
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [N_OUT-1:0]                 golden,
  input  logic [N_OUT-1:0]                 dut_out,
  output logic [N_IN-1:0]                  dut_in,
  output logic                             busy,
  output logic                             done,
  output logic                             pass,
  output logic [N_OUT-1:0]                 signature,
`ifdef GATE_MODEL_BIST_TOGGLE_EN
  output logic [N_OUT-1:0]                 toggle_mask,
`endif
  output logic [$clog2(PATTERNS):0]        pattern_cnt
);

  localparam int unsigned CNT_W = $clog2(PATTERNS) + 1;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [N_IN-1:0]  SEED = (LFSR_SEED == '0) ? N_IN'(1) : LFSR_SEED;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PATTERNS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [N_IN-1:0]  lfsr_q, lfsr_d;
  logic [N_OUT-1:0] misr_q, misr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [N_IN-1:0]  lfsr_step;
  logic [N_OUT-1:0] misr_step;
  logic             sig_ok;

`ifdef GATE_MODEL_BIST_TOGGLE_EN
  logic [N_OUT-1:0] tgl_q, tgl_d;
  logic [N_OUT-1:0] prev_q, prev_d;
`endif

  // One LFSR / MISR step; dut_out is compacted at the edge that advances dut_in.
  always_comb begin
    lfsr_step = {lfsr_q[N_IN-2:0], ^(lfsr_q & LFSR_TAPS)};
    misr_step = N_OUT'({misr_q[N_OUT-2:0], ^(misr_q & MISR_TAPS)}) ^ dut_out;
  end

  // Next-state and datapath decode.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    sig_ok  = (misr_step == golden);
`ifdef GATE_MODEL_BIST_TOGGLE_EN
    tgl_d   = tgl_q;
    prev_d  = prev_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          lfsr_d  = SEED;
          misr_d  = '0;
          cnt_d   = '0;
          pass_d  = 1'b0;
`ifdef GATE_MODEL_BIST_TOGGLE_EN
          tgl_d   = '0;
`endif
        end
      end
      RUN: begin
        lfsr_d = lfsr_step;
        misr_d = misr_step;
        cnt_d  = cnt_q + CNT_W'(1);
`ifdef GATE_MODEL_BIST_TOGGLE_EN
        // The first pattern of a run has no predecessor to compare against.
        prev_d = dut_out;
        if (cnt_q != '0) begin
          tgl_d = tgl_q | (dut_out ^ prev_q);
        end
        sig_ok = sig_ok && (&tgl_d);
`endif
        if (cnt_q == LAST) begin
          state_d = DONE;
          pass_d  = sig_ok;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // Register bank; synchronous reset overrides any run in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      misr_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
`ifdef GATE_MODEL_BIST_TOGGLE_EN
      tgl_q   <= '0;
      prev_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
`ifdef GATE_MODEL_BIST_TOGGLE_EN
      tgl_q   <= tgl_d;
      prev_q  <= prev_d;
`endif
    end
  end

  assign dut_in      = lfsr_q;
  assign signature   = misr_q;
  assign pattern_cnt = cnt_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
`ifdef GATE_MODEL_BIST_TOGGLE_EN
  assign toggle_mask = tgl_q;
`endif

endmodule

// File: tb/tb_gate_model_bist.sv
// tb_gate_model_bist: directed bench for gate_model_bist.
// Instance a: PATTERNS=4 with constant model output.
// Instance b: PATTERNS=256, held start, restart, reset mid-run.
// Instance c: seed 0 driving a small combinational gate model.
module tb_gate_model_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

`ifdef GATE_MODEL_BIST_TOGGLE_EN
  localparam logic CONST_PASS = 1'b0;
`else
  localparam logic CONST_PASS = 1'b1;
`endif

  // Instance a
  logic        rst_a, start_a;
  logic [9:0]  golden_a, dout_a, sig_a;
  logic [22:0] din_a;
  logic        busy_a, done_a, pass_a;
  logic [2:0]  cnt_a;
  // Instance b
  logic        rst_b, start_b;
  logic [9:0]  golden_b, dout_b, sig_b;
  logic [22:0] din_b;
  logic        busy_b, done_b, pass_b;
  logic [8:0]  cnt_b;
  // Instance c
  logic        rst_c, start_c;
  logic [9:0]  golden_c, dout_c, sig_c;
  logic [22:0] din_c;
  logic        busy_c, done_c, pass_c;
  logic [8:0]  cnt_c;
`ifdef GATE_MODEL_BIST_TOGGLE_EN
  logic [9:0]  tm_a, tm_b, tm_c;
`endif

  function automatic logic [9:0] gm(input logic [22:0] x);
    return x[9:0] ^ (x[19:10] & {x[22:20], x[6:0]});
  endfunction

  assign dout_c = gm(din_c);

  gate_model_bist #(.PATTERNS(4)) u_a (
    .clk(clk), .rst(rst_a), .start(start_a), .golden(golden_a), .dut_out(dout_a),
    .dut_in(din_a), .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a),
`ifdef GATE_MODEL_BIST_TOGGLE_EN
    .toggle_mask(tm_a),
`endif
    .pattern_cnt(cnt_a));

  gate_model_bist #(.PATTERNS(256)) u_b (
    .clk(clk), .rst(rst_b), .start(start_b), .golden(golden_b), .dut_out(dout_b),
    .dut_in(din_b), .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b),
`ifdef GATE_MODEL_BIST_TOGGLE_EN
    .toggle_mask(tm_b),
`endif
    .pattern_cnt(cnt_b));

  gate_model_bist #(.PATTERNS(256), .LFSR_SEED(23'h000000)) u_c (
    .clk(clk), .rst(rst_c), .start(start_c), .golden(golden_c), .dut_out(dout_c),
    .dut_in(din_c), .busy(busy_c), .done(done_c), .pass(pass_c), .signature(sig_c),
`ifdef GATE_MODEL_BIST_TOGGLE_EN
    .toggle_mask(tm_c),
`endif
    .pattern_cnt(cnt_c));

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [22:0] ml;
  logic [9:0]  mm, mo, mprev, mmask;

  initial begin
    rst_a = 1'b1; start_a = 1'b0; golden_a = 10'h00F; dout_a = 10'h001;
    rst_b = 1'b1; start_b = 1'b0; golden_b = 10'h000; dout_b = 10'h000;
    rst_c = 1'b1; start_c = 1'b0; golden_c = 10'h000;
    tick();
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    // Reset state
    chk("a_rst_busy", 32'(busy_a), 32'd0);
    chk("a_rst_done", 32'(done_a), 32'd0);
    chk("a_rst_pass", 32'(pass_a), 32'd0);
    chk("a_rst_din",  32'(din_a),  32'h1);
    chk("a_rst_sig",  32'(sig_a),  32'h0);
    chk("a_rst_cnt",  32'(cnt_a),  32'd0);
    chk("c_seed0_din", 32'(din_c), 32'h1);

    // PATTERNS=4, dut_out=1: dut_in 1,2,4,8 then DONE with signature F
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("a_run_busy", 32'(busy_a), 32'd1);
    chk("a_pat0", 32'(din_a), 32'h1);
    tick(); chk("a_pat1", 32'(din_a), 32'h2);
    tick(); chk("a_pat2", 32'(din_a), 32'h4);
    chk("a_done_early", 32'(done_a), 32'd0);
    tick(); chk("a_pat3", 32'(din_a), 32'h8);
    chk("a_sig_mid", 32'(sig_a), 32'h7);
    tick();
    chk("a_done", 32'(done_a), 32'd1);
    chk("a_busy_done", 32'(busy_a), 32'd0);
    chk("a_sig", 32'(sig_a), 32'h00F);
    chk("a_pass", 32'(pass_a), 32'(CONST_PASS));
    chk("a_cnt", 32'(cnt_a), 32'd4);
`ifdef GATE_MODEL_BIST_TOGGLE_EN
    chk("a_tmask", 32'(tm_a), 32'h0);
`endif
    tick(3);
    chk("a_hold_done", 32'(done_a), 32'd1);
    chk("a_hold_sig", 32'(sig_a), 32'h00F);
    chk("a_hold_din", 32'(din_a), 32'h10);
    chk("a_hold_cnt", 32'(cnt_a), 32'd4);

    // Restart from DONE with wrong golden
    golden_a = 10'h00E;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("a_re_done", 32'(done_a), 32'd0);
    chk("a_re_busy", 32'(busy_a), 32'd1);
    chk("a_re_din", 32'(din_a), 32'h1);
    chk("a_re_cnt", 32'(cnt_a), 32'd0);
    tick(4);
    chk("a_bad_done", 32'(done_a), 32'd1);
    chk("a_bad_pass", 32'(pass_a), 32'd0);
    chk("a_bad_sig", 32'(sig_a), 32'h00F);

    // PATTERNS=256, dut_out=0, start held high through the run
    start_b = 1'b1;
    tick();
    chk("b_busy", 32'(busy_b), 32'd1);
    tick(255);
    chk("b_done_255", 32'(done_b), 32'd0);
    chk("b_cnt_255", 32'(cnt_b), 32'd255);
    tick();
    chk("b_done_256", 32'(done_b), 32'd1);
    chk("b_sig", 32'(sig_b), 32'h0);
    chk("b_pass", 32'(pass_b), 32'(CONST_PASS));
    chk("b_cnt", 32'(cnt_b), 32'd256);
`ifdef GATE_MODEL_BIST_TOGGLE_EN
    chk("b_tmask", 32'(tm_b), 32'h0);
`endif
    // start still high in DONE: restart
    tick();
    chk("b_re_done", 32'(done_b), 32'd0);
    chk("b_re_pass", 32'(pass_b), 32'd0);
    chk("b_re_busy", 32'(busy_b), 32'd1);
    dout_b = 10'h155;
    tick(100);
    chk("b_cnt_100", 32'(cnt_b), 32'd100);
    // Reset at pattern 100 with start also high: reset wins
    rst_b = 1'b1;
    tick();
    start_b = 1'b0;
    rst_b = 1'b0;
    chk("b_mrst_busy", 32'(busy_b), 32'd0);
    chk("b_mrst_done", 32'(done_b), 32'd0);
    chk("b_mrst_din", 32'(din_b), 32'h000001);
    chk("b_mrst_sig", 32'(sig_b), 32'h0);
    chk("b_mrst_cnt", 32'(cnt_b), 32'd0);
    tick(2);
    chk("b_idle_busy", 32'(busy_b), 32'd0);

    // Seed 0 with the gate model: reference signature from a behavioural loop
    ml = 23'h000001; mm = '0; mprev = '0; mmask = '0;
    for (int i = 0; i < 256; i++) begin
      mo = gm(ml);
      if (i > 0) mmask = mmask | (mo ^ mprev);
      mprev = mo;
      mm = {mm[8:0], ^(mm & 10'h240)} ^ mo;
      ml = {ml[21:0], ^(ml & 23'h420000)};
    end
    golden_c = mm;
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    chk("c_pat0", 32'(din_c), 32'h1);
    tick(256);
    chk("c_done", 32'(done_c), 32'd1);
    chk("c_sig", 32'(sig_c), 32'(mm));
    chk("c_din_final", 32'(din_c), 32'(ml));
`ifdef GATE_MODEL_BIST_TOGGLE_EN
    chk("c_tmask", 32'(tm_c), 32'(mmask));
    chk("c_pass", 32'(pass_c), 32'(&mmask));
`else
    chk("c_pass", 32'(pass_c), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/gate_model_bist.md
Name: gate_model_bist

Overview:
- Built-in self-test harness for the combinational gate models in the simulator gate library.
- Acts as the stimulus end of the 23-input / 10-output gate-model interface:
  - drives pseudo-random patterns into the model inputs from a 23-bit LFSR;
  - compacts the 10 model outputs into a MISR signature;
  - compares the final signature against a golden value.
- Sits between the practical-course test controller (start/done handshake) and one gate-model instance.

Parameters:
- N_IN, 23, gate-model input width (LFSR width).
- N_OUT, 10, gate-model output width (MISR width).
- PATTERNS, 256, patterns applied per run; legal range 2..2^20.
- LFSR_TAPS, 23'h420000, Fibonacci feedback mask (x^23+x^18+1).
- LFSR_SEED, 23'h000001, LFSR load value; a value of zero is replaced by 1.
- MISR_TAPS, 10'h240, MISR feedback mask (x^10+x^7+1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  run request pulse/level.
- golden  in  N_OUT  expected signature; sampled in DONE entry cycle.
- dut_out  in  N_OUT  gate-model outputs (combinational from dut_in).
- dut_in  out  N_IN  gate-model inputs; driven directly by the LFSR register.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  signature==golden; valid while done=1.
- signature  out  N_OUT  current MISR contents.
- pattern_cnt  out  $clog2(PATTERNS)+1  patterns applied so far.

Behaviour:
- Reset (rst=1 at an edge) forces the following, and overrides everything including mid-run:
  - state=IDLE;
  - lfsr=seed, so dut_in=seed;
  - misr=0, pattern_cnt=0;
  - busy=0, done=0, pass=0.
- LFSR step: lfsr <= {lfsr[N_IN-2:0], ^(lfsr & LFSR_TAPS)}.
- MISR step: misr <= {misr[N_OUT-2:0], ^(misr & MISR_TAPS)} ^ dut_out.
- dut_out is sampled at the same edge that advances dut_in. The model is purely combinational, so each pattern gets exactly one cycle.
- State machine:
  - IDLE:
    - start=1 -> RUN; loads lfsr=seed, misr=0, cnt=0.
  - RUN, every cycle:
    - MISR step, LFSR step, cnt+1.
    - When cnt==PATTERNS-1 at that edge -> DONE.
    - start is ignored in RUN.
    - Exactly PATTERNS patterns are applied: seed, then successive LFSR states.
  - DONE:
    - lfsr, misr and cnt are frozen.
    - pass is registered on the DONE entry edge as (misr_next==golden), using golden sampled in that same cycle.
    - start=1 -> RUN with a full reload; pass and done clear on that edge.
    - Otherwise DONE is held indefinitely.
- Latency: start sampled at edge k -> busy=1 after edge k, done=1 after edge k+PATTERNS.
- pattern_cnt:
  - counts 0..PATTERNS;
  - equals PATTERNS in DONE;
  - never wraps.
- signature is always visible; it is meaningful only in DONE.
- start and rst asserted together: rst wins.

Optional Feature:
- Macro: GATE_MODEL_BIST_TOGGLE_EN.
- When defined:
  - Adds output port toggle_mask (out, N_OUT).
  - Bit i is set when dut_out[i] differs between two consecutive RUN cycles.
  - Cleared on reset and on RUN entry; frozen in DONE.
  - pass additionally requires toggle_mask to be all ones. This catches stuck outputs that alias in the MISR.
- When undefined:
  - Port is absent.
  - pass depends on the signature compare only.
  - No toggle logic is present.

Test Plan:
- Reset mid-RUN (PATTERNS=256, rst at pattern 100) -> next cycle busy=0, done=0, dut_in=23'h000001, signature=0, pattern_cnt=0.
- PATTERNS=4, seed 1, dut_out tied 10'h001, golden=10'h00F:
  - dut_in sequence 1,2,4,8;
  - done one cycle after the 4th pattern;
  - signature=10'h00F, pass=1, pattern_cnt=4.
- Same as previous with golden=10'h00E -> pass=0, done=1.
- dut_out tied 0, PATTERNS=256, golden=0:
  - signature=0, pass=1;
  - with GATE_MODEL_BIST_TOGGLE_EN: toggle_mask=0, pass=0.
- start held high through RUN -> run length unchanged (done exactly PATTERNS cycles after start). start in DONE -> restart, done and pass clear next cycle.
- LFSR_SEED=0 -> first dut_in=23'h000001. Connected to a gate-model instance, signature matches a reference-model golden for 256 patterns.
